// File: rtl/tlp_defragmenter_pkg.sv
// tlp_defragmenter_pkg: shared widths, valid-bytes encoding and fsm states for tlp defragmentation
package tlp_defragmenter_pkg;
  localparam int DLL_TLP_WIDTH = 256;
  localparam int DLL_LENGTH_WIDTH = 10;
  localparam int RX_FIFO_ADD_WIDTH = 6;
  typedef logic [2:0] valid_bytes_encoding;
  typedef enum logic [1:0] {IDLE, RECV, DROP} fsm_state_e;
endpackage

// File: rtl/tlp_defragmenter_if.sv
// Defragmentation_Interface: groups the dll-side and rx-fifo-side defragmenter signals
interface Defragmentation_Interface
  import tlp_defragmenter_pkg::*;
#(
  parameter int DLL_TLP_WIDTH = tlp_defragmenter_pkg::DLL_TLP_WIDTH,
  parameter int DLL_LENGTH_WIDTH = tlp_defragmenter_pkg::DLL_LENGTH_WIDTH,
  parameter int RX_FIFO_ADD_WIDTH = tlp_defragmenter_pkg::RX_FIFO_ADD_WIDTH
)(
  input logic clk,
  input logic arst
);
  logic sop, eop, TLP_valid, Halt;
  valid_bytes_encoding Valid_Bytes;
  logic [DLL_LENGTH_WIDTH-1:0] Length;
  logic [DLL_TLP_WIDTH-1:0] TLP;
  logic [RX_FIFO_ADD_WIDTH:0] fifo_free;
  logic wr_en, commit, discard, err_malformed, err_overflow;
  logic [DLL_TLP_WIDTH-1:0] wr_data;
  modport DLL_DEFRAGMENTATION (
    input clk, arst, sop, eop, TLP_valid, Valid_Bytes, Length, TLP,
    output Halt
  );
  modport DEFRAGMENTATION_RX_FIFO (
    input clk, arst, fifo_free,
    output wr_en, wr_data, commit, discard, err_malformed, err_overflow
  );
endinterface

// File: rtl/tlp_defragmenter_vb_decoder.sv
// vb_decoder: converts the valid-bytes code into a 1..8 dw count
module vb_decoder
  import tlp_defragmenter_pkg::*;
(
  input  valid_bytes_encoding vb,
  output logic [3:0]          dw
);
  assign dw = 4'(vb) + 4'd1;
endmodule

// File: rtl/tlp_defragmenter.sv
// tlp_defragmenter: reassembles dll beats into rx-fifo writes with commit/discard framing and error pulses
module tlp_defragmenter
  import tlp_defragmenter_pkg::*;
#(
  parameter int DLL_TLP_WIDTH = tlp_defragmenter_pkg::DLL_TLP_WIDTH,
  parameter int DLL_LENGTH_WIDTH = tlp_defragmenter_pkg::DLL_LENGTH_WIDTH,
  parameter int RX_FIFO_ADD_WIDTH = tlp_defragmenter_pkg::RX_FIFO_ADD_WIDTH
)(
  input  logic                         clk,
  input  logic                         arst,
  input  logic                         sop,
  input  logic                         eop,
  input  logic                         TLP_valid,
  input  valid_bytes_encoding          Valid_Bytes,
  input  logic [DLL_LENGTH_WIDTH-1:0]  Length,
  input  logic [DLL_TLP_WIDTH-1:0]     TLP,
  output logic                         Halt,
  input  logic [RX_FIFO_ADD_WIDTH:0]   fifo_free,
  output logic                         wr_en,
  output logic [DLL_TLP_WIDTH-1:0]     wr_data,
  output logic                         commit,
  output logic                         discard,
  output logic                         err_malformed,
  output logic                         err_overflow
);
  localparam int CW = DLL_LENGTH_WIDTH + 1;
  fsm_state_e st, st_nx;
  logic [CW-1:0] dw_cnt, base, total;
  logic [CW:0] sum;
  logic [DLL_LENGTH_WIDTH-1:0] len_q, len_cur;
  logic [3:0] beat_dw;
  logic start, abort, orphan, ovf, wr_nx, done, match, c_pipe, d_pipe;
  vb_decoder u_vb_decoder (.vb(Valid_Bytes), .dw(beat_dw));
  always_comb begin
    start = TLP_valid & sop;
    abort = start & (st == RECV);
    orphan = TLP_valid & ~sop & (st == IDLE);
    ovf = TLP_valid & (sop | st == RECV) & (fifo_free == '0);
    wr_nx = TLP_valid & (sop | st == RECV) & ~ovf;
    done = wr_nx & eop;
    base = sop ? '0 : dw_cnt;
    sum = {1'b0, base} + (CW+1)'(beat_dw);
    total = sum[CW] ? '1 : sum[CW-1:0];
    len_cur = start ? Length : len_q;
    match = total == {1'b0, len_cur};
    st_nx = ovf ? (eop ? IDLE : DROP) :
            wr_nx ? (eop ? IDLE : RECV) :
            (TLP_valid & eop & st == DROP) ? IDLE : st;
  end
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      st <= IDLE;
      dw_cnt <= '0;
      len_q <= '0;
      wr_en <= 1'b0;
      wr_data <= '0;
      c_pipe <= 1'b0;
      d_pipe <= 1'b0;
      commit <= 1'b0;
      discard <= 1'b0;
      err_malformed <= 1'b0;
      err_overflow <= 1'b0;
      Halt <= 1'b1;
    end else begin
      st <= st_nx;
      if (wr_nx) dw_cnt <= total;
      len_q <= len_cur;
      wr_en <= wr_nx;
      if (wr_nx) wr_data <= TLP;
      c_pipe <= done & match;
      d_pipe <= done & ~match;
      commit <= c_pipe;
      discard <= d_pipe | ((abort | ovf) & ~c_pipe);
      err_malformed <= d_pipe | abort | orphan;
      err_overflow <= ovf;
      Halt <= fifo_free <= (RX_FIFO_ADD_WIDTH+1)'(2);
    end
  end
endmodule

// File: tb/tb_tlp_defragmenter.sv
// tb_tlp_defragmenter: directed self-checking bench for tlp_defragmenter
module tb_tlp_defragmenter;
  logic clk = 1'b0;
  logic arst = 1'b1;
  logic sop = 1'b0, eop = 1'b0, TLP_valid = 1'b0;
  logic [2:0] Valid_Bytes = '0;
  logic [9:0] Length = '0;
  logic [255:0] TLP = '0;
  logic [6:0] fifo_free = 7'd64;
  logic Halt, wr_en, commit, discard, err_malformed, err_overflow;
  logic [255:0] wr_data;
  int errors = 0, checks = 0;
  int cyc = 0, n_wr = 0, n_commit = 0, n_discard = 0, n_mal = 0, n_ovf = 0, n_both = 0;
  int last_wr_cyc = 0, last_commit_cyc = 0, last_discard_cyc = 0;
  logic [255:0] last_wr_data = '0;
  int b_wr, b_commit, b_discard, b_mal, b_ovf;
  tlp_defragmenter dut (
    .clk(clk), .arst(arst), .sop(sop), .eop(eop), .TLP_valid(TLP_valid),
    .Valid_Bytes(Valid_Bytes), .Length(Length), .TLP(TLP), .Halt(Halt),
    .fifo_free(fifo_free), .wr_en(wr_en), .wr_data(wr_data), .commit(commit),
    .discard(discard), .err_malformed(err_malformed), .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (wr_en) begin
      n_wr <= n_wr + 1;
      last_wr_cyc <= cyc;
      last_wr_data <= wr_data;
    end
    if (commit) begin
      n_commit <= n_commit + 1;
      last_commit_cyc <= cyc;
    end
    if (discard) begin
      n_discard <= n_discard + 1;
      last_discard_cyc <= cyc;
    end
    if (err_malformed) n_mal <= n_mal + 1;
    if (err_overflow) n_ovf <= n_ovf + 1;
    if (commit && discard) n_both <= n_both + 1;
  end
  task automatic beat(input logic s, input logic e, input logic [2:0] vb, input logic [9:0] len, input logic [255:0] d);
    @(negedge clk);
    TLP_valid = 1'b1; sop = s; eop = e; Valid_Bytes = vb; Length = len; TLP = d;
  endtask
  task automatic idle(input int n);
    @(negedge clk);
    TLP_valid = 1'b0; sop = 1'b0; eop = 1'b0;
    repeat (n) @(negedge clk);
  endtask
  task automatic snap;
    b_wr = n_wr; b_commit = n_commit; b_discard = n_discard; b_mal = n_mal; b_ovf = n_ovf;
  endtask
  task automatic test_reset;
    arst = 1'b1;
    #2 arst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL reset_halt: got %b expected 1", Halt); end
    checks++; if ({wr_en, commit, discard, err_malformed, err_overflow} !== 5'b0) begin errors++; $display("FAIL reset_pulses: got %b expected 00000", {wr_en, commit, discard, err_malformed, err_overflow}); end
    checks++; if (wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0", wr_data); end
    arst = 1'b1;
    @(negedge clk);
    checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL reset_release_halt: got %b expected 0", Halt); end
    idle(2);
  endtask
  task automatic test_good_tlp;
    snap();
    beat(1, 0, 3'd7, 10'd20, 256'h11);
    beat(0, 0, 3'd7, 10'd20, 256'h22);
    beat(0, 1, 3'd3, 10'd20, 256'h33);
    idle(4);
    checks++; if (n_wr - b_wr !== 3) begin errors++; $display("FAIL good_writes: got %0d expected 3", n_wr - b_wr); end
    checks++; if (n_commit - b_commit !== 1) begin errors++; $display("FAIL good_commit: got %0d expected 1", n_commit - b_commit); end
    checks++; if (last_commit_cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL good_commit_timing: got cycle %0d expected %0d", last_commit_cyc, last_wr_cyc + 1); end
    checks++; if (last_wr_data !== 256'h33) begin errors++; $display("FAIL good_last_data: got %h expected 33", last_wr_data); end
    checks++; if ((n_discard - b_discard) + (n_mal - b_mal) + (n_ovf - b_ovf) !== 0) begin errors++; $display("FAIL good_no_errors: got %0d expected 0", (n_discard - b_discard) + (n_mal - b_mal) + (n_ovf - b_ovf)); end
  endtask
  task automatic test_short_tlp;
    snap();
    beat(1, 0, 3'd7, 10'd20, 256'h44);
    beat(0, 1, 3'd7, 10'd20, 256'h55);
    idle(4);
    checks++; if (n_wr - b_wr !== 2) begin errors++; $display("FAIL short_writes: got %0d expected 2", n_wr - b_wr); end
    checks++; if (n_discard - b_discard !== 1) begin errors++; $display("FAIL short_discard: got %0d expected 1", n_discard - b_discard); end
    checks++; if (n_mal - b_mal !== 1) begin errors++; $display("FAIL short_malformed: got %0d expected 1", n_mal - b_mal); end
    checks++; if (n_commit - b_commit !== 0) begin errors++; $display("FAIL short_commit: got %0d expected 0", n_commit - b_commit); end
    checks++; if (last_discard_cyc !== last_wr_cyc + 1) begin errors++; $display("FAIL short_discard_timing: got cycle %0d expected %0d", last_discard_cyc, last_wr_cyc + 1); end
  endtask
  task automatic test_single_and_orphan;
    snap();
    beat(1, 1, 3'd3, 10'd4, 256'hABCD);
    idle(4);
    checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL single_writes: got %0d expected 1", n_wr - b_wr); end
    checks++; if (n_commit - b_commit !== 1) begin errors++; $display("FAIL single_commit: got %0d expected 1", n_commit - b_commit); end
    checks++; if (last_wr_data !== 256'hABCD) begin errors++; $display("FAIL single_data: got %h expected abcd", last_wr_data); end
    snap();
    beat(0, 0, 3'd7, 10'd0, 256'hDEAD);
    idle(4);
    checks++; if (n_mal - b_mal !== 1) begin errors++; $display("FAIL orphan_malformed: got %0d expected 1", n_mal - b_mal); end
    checks++; if (n_wr - b_wr !== 0) begin errors++; $display("FAIL orphan_writes: got %0d expected 0", n_wr - b_wr); end
  endtask
  task automatic test_halt_overflow;
    snap();
    fifo_free = 7'd3;
    beat(1, 0, 3'd7, 10'd16, 256'h66);
    @(negedge clk);
    TLP_valid = 1'b0; sop = 1'b0;
    checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL halt_at_3: got %b expected 0", Halt); end
    fifo_free = 7'd2;
    @(negedge clk);
    checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL halt_at_2: got %b expected 1", Halt); end
    fifo_free = 7'd0;
    beat(0, 0, 3'd7, 10'd16, 256'h77);
    beat(0, 0, 3'd7, 10'd16, 256'h88);
    beat(0, 1, 3'd7, 10'd16, 256'h99);
    idle(3);
    checks++; if (n_ovf - b_ovf !== 1) begin errors++; $display("FAIL ovf_pulse: got %0d expected 1", n_ovf - b_ovf); end
    checks++; if (n_discard - b_discard !== 1) begin errors++; $display("FAIL ovf_discard: got %0d expected 1", n_discard - b_discard); end
    checks++; if (n_wr - b_wr !== 1) begin errors++; $display("FAIL ovf_writes: got %0d expected 1", n_wr - b_wr); end
    checks++; if (n_mal - b_mal !== 0) begin errors++; $display("FAIL ovf_malformed: got %0d expected 0", n_mal - b_mal); end
    fifo_free = 7'd64;
    idle(2);
    checks++; if (Halt !== 1'b0) begin errors++; $display("FAIL halt_release: got %b expected 0", Halt); end
    snap();
    beat(1, 1, 3'd0, 10'd1, 256'h1);
    idle(4);
    checks++; if (n_commit - b_commit !== 1) begin errors++; $display("FAIL after_drop_commit: got %0d expected 1", n_commit - b_commit); end
  endtask
  task automatic test_sop_abort;
    snap();
    beat(1, 0, 3'd7, 10'd16, 256'hA1);
    beat(1, 0, 3'd7, 10'd16, 256'hB1);
    beat(0, 1, 3'd7, 10'd16, 256'hB2);
    idle(4);
    checks++; if (n_wr - b_wr !== 3) begin errors++; $display("FAIL abort_writes: got %0d expected 3", n_wr - b_wr); end
    checks++; if (n_discard - b_discard !== 1) begin errors++; $display("FAIL abort_discard: got %0d expected 1", n_discard - b_discard); end
    checks++; if (n_mal - b_mal !== 1) begin errors++; $display("FAIL abort_malformed: got %0d expected 1", n_mal - b_mal); end
    checks++; if (n_commit - b_commit !== 1) begin errors++; $display("FAIL abort_commit: got %0d expected 1", n_commit - b_commit); end
    checks++; if (!(last_discard_cyc < last_commit_cyc)) begin errors++; $display("FAIL abort_order: got discard %0d commit %0d expected discard earlier", last_discard_cyc, last_commit_cyc); end
  endtask
  task automatic test_back_to_back;
    snap();
    beat(1, 1, 3'd1, 10'd2, 256'hC1);
    beat(1, 0, 3'd7, 10'd9, 256'hC2);
    beat(0, 1, 3'd0, 10'd9, 256'hC3);
    beat(1, 1, 3'd7, 10'd8, 256'hC4);
    idle(4);
    checks++; if (n_wr - b_wr !== 4) begin errors++; $display("FAIL b2b_writes: got %0d expected 4", n_wr - b_wr); end
    checks++; if (n_commit - b_commit !== 3) begin errors++; $display("FAIL b2b_commits: got %0d expected 3", n_commit - b_commit); end
    checks++; if (n_discard - b_discard !== 0) begin errors++; $display("FAIL b2b_discard: got %0d expected 0", n_discard - b_discard); end
  endtask
  task automatic test_reset_mid_tlp;
    snap();
    beat(1, 0, 3'd7, 10'd16, 256'hE1);
    @(negedge clk);
    TLP_valid = 1'b0; sop = 1'b0;
    arst = 1'b0;
    @(negedge clk);
    checks++; if (Halt !== 1'b1) begin errors++; $display("FAIL midreset_halt: got %b expected 1", Halt); end
    arst = 1'b1;
    beat(0, 1, 3'd7, 10'd16, 256'hE2);
    idle(4);
    checks++; if (n_commit - b_commit !== 0) begin errors++; $display("FAIL midreset_commit: got %0d expected 0", n_commit - b_commit); end
    checks++; if (n_mal - b_mal !== 1) begin errors++; $display("FAIL midreset_orphan: got %0d expected 1", n_mal - b_mal); end
  endtask
  initial begin
    test_reset();
    test_good_tlp();
    test_short_tlp();
    test_single_and_orphan();
    test_halt_overflow();
    test_sop_abort();
    test_back_to_back();
    test_reset_mid_tlp();
    checks++; if (n_both !== 0) begin errors++; $display("FAIL commit_discard_overlap: got %0d expected 0", n_both); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
